// File: rtl/lsu_request_scheduler.sv
// Shares one load/store unit between the store-commit port (0) and the load-issue port (1):
// per-port request FIFOs, round-robin grant, and a single in-flight op with a watchdog.
module lsu_request_scheduler #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_is_load,
    input  logic [1:0]           req_is_store,
    input  logic [1:0]           req_is_byte,
    input  logic [1:0]           req_is_word,
    input  logic [63:0]          req_rs1,
    input  logic [63:0]          req_rs2,
    input  logic [63:0]          req_imm,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [31:0]          lsu_rs1_data,
    output logic [31:0]          lsu_rs2_data,
    output logic [31:0]          lsu_imm,
    output logic                 lsu_is_load,
    output logic                 lsu_is_store,
    output logic                 lsu_is_byte,
    output logic                 lsu_is_word,
    input  logic [31:0]          lsu_read_data,
    input  logic                 lsu_mem_done,
    input  logic [31:0]          lsu_mem_address,
    output logic                 resp_valid,
    output logic                 resp_port,
    output logic [TAG_W-1:0]     resp_tag,
    output logic [31:0]          resp_data,
    output logic [31:0]          resp_addr,
    output logic                 resp_err,
    output logic                 busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic             is_load;
        logic             is_store;
        logic             is_byte;
        logic             is_word;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    op_t              fifo_mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0] count  [2];
    op_t              in_op  [2];
    op_t              head   [2];
    logic [1:0]       non_empty, push, pop;
    op_t              op_q, grant_op;
    logic             grant, grant_port, grant_ok;
    logic             last_grant_q, resp_port_q, resp_err_q, ready_en_q;
    logic [31:0]      resp_data_q, resp_addr_q;
    logic [WD_W-1:0]  wd_q;

    always_comb begin
        grant      = (state_q == StIdle) && (non_empty != 2'b00);
        grant_port = (&non_empty) ? ~last_grant_q : non_empty[1];
        for (int p = 0; p < 2; p++) begin
            in_op[p]          = '0;
            in_op[p].is_load  = req_is_load[p];
            in_op[p].is_store = req_is_store[p];
            in_op[p].is_byte  = req_is_byte[p];
            in_op[p].is_word  = req_is_word[p];
            in_op[p].rs1      = req_rs1[p*32 +: 32];
            in_op[p].rs2      = req_rs2[p*32 +: 32];
            in_op[p].imm      = req_imm[p*32 +: 32];
            in_op[p].tag      = req_tag[p*TAG_W +: TAG_W];
            head[p]           = fifo_mem[p][rd_ptr[p]];
            non_empty[p]      = (count[p] != '0);
            // ready comes from registered state only; it is held low until the first clock
            req_ready[p]      = ready_en_q && (count[p] != CNT_W'(FIFO_DEPTH));
            push[p]           = req_valid[p] & req_ready[p];
            pop[p]            = grant && (grant_port == 1'(p));
        end
        grant_op = head[grant_port];
        grant_ok = (grant_op.is_load ^ grant_op.is_store) & (grant_op.is_byte ^ grant_op.is_word);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
                for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[p][i] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    fifo_mem[p][wr_ptr[p]] <= in_op[p];
                    wr_ptr[p]              <= wr_ptr[p] + 1'b1;
                end
                if (pop[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
                if (push[p] && !pop[p]) count[p] <= count[p] + 1'b1;
                else if (pop[p] && !push[p]) count[p] <= count[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = grant_ok ? StIssue : StResp;
            StIssue: state_d = StWait;
            StWait:  if (lsu_mem_done || (wd_q == WD_W'(TIMEOUT))) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= '0;
            last_grant_q <= 1'b1;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_addr_q  <= '0;
            wd_q         <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        op_q         <= grant_op;
                        last_grant_q <= grant_port;
                        resp_port_q  <= grant_port;
                        resp_err_q   <= ~grant_ok;
                        resp_data_q  <= '0;
                        resp_addr_q  <= '0;
                    end
                end
                StIssue: begin
                    resp_addr_q <= lsu_mem_address;
                    wd_q        <= '0;
                end
                StWait: begin
                    if (lsu_mem_done) begin
                        resp_data_q <= op_q.is_load ? lsu_read_data : 32'h0;
                    end else if (wd_q == WD_W'(TIMEOUT)) begin
                        resp_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_rs1_data = op_q.rs1;
    assign lsu_rs2_data = op_q.rs2;
    assign lsu_imm      = op_q.imm;
    assign lsu_is_load  = (state_q == StIssue) & op_q.is_load;
    assign lsu_is_store = (state_q == StIssue) & op_q.is_store;
    assign lsu_is_byte  = (state_q == StIssue) & op_q.is_byte;
    assign lsu_is_word  = (state_q == StIssue) & op_q.is_word;
    assign resp_valid   = (state_q == StResp);
    assign resp_port    = resp_port_q;
    assign resp_tag     = op_q.tag;
    assign resp_data    = resp_data_q;
    assign resp_addr    = resp_addr_q;
    assign resp_err     = resp_err_q;
    assign busy         = (state_q != StIdle) || (non_empty != 2'b00);

endmodule

// File: tb/tb_lsu_request_scheduler.sv
// Directed bench for lsu_request_scheduler: a tiny LSU model answers one cycle after ISSUE,
// a negedge monitor logs issue pulses and responses, and directed cases check them.
module tb_lsu_request_scheduler;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned TAG_W      = 6;
    localparam int unsigned TIMEOUT    = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid, req_ready;
    logic [1:0]         req_is_load, req_is_store, req_is_byte, req_is_word;
    logic [63:0]        req_rs1, req_rs2, req_imm;
    logic [2*TAG_W-1:0] req_tag;
    logic [31:0]        lsu_rs1_data, lsu_rs2_data, lsu_imm;
    logic               lsu_is_load, lsu_is_store, lsu_is_byte, lsu_is_word;
    logic [31:0]        lsu_read_data, lsu_mem_address;
    logic               lsu_mem_done;
    logic               resp_valid, resp_port, resp_err, busy;
    logic [TAG_W-1:0]   resp_tag;
    logic [31:0]        resp_data, resp_addr;

    lsu_request_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TAG_W     (TAG_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_load    (req_is_load),
        .req_is_store   (req_is_store),
        .req_is_byte    (req_is_byte),
        .req_is_word    (req_is_word),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_imm        (req_imm),
        .req_tag        (req_tag),
        .lsu_rs1_data   (lsu_rs1_data),
        .lsu_rs2_data   (lsu_rs2_data),
        .lsu_imm        (lsu_imm),
        .lsu_is_load    (lsu_is_load),
        .lsu_is_store   (lsu_is_store),
        .lsu_is_byte    (lsu_is_byte),
        .lsu_is_word    (lsu_is_word),
        .lsu_read_data  (lsu_read_data),
        .lsu_mem_done   (lsu_mem_done),
        .lsu_mem_address(lsu_mem_address),
        .resp_valid     (resp_valid),
        .resp_port      (resp_port),
        .resp_tag       (resp_tag),
        .resp_data      (resp_data),
        .resp_addr      (resp_addr),
        .resp_err       (resp_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic pending = 1'b0;
    logic auto_done;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) pending <= lsu_is_load | lsu_is_store;
    assign lsu_mem_done    = pending & auto_done;
    assign lsu_mem_address = lsu_rs1_data + lsu_imm;

    typedef struct {
        int               cyc;
        logic             port;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic [31:0]      addr;
        logic             err;
    } resp_t;
    typedef struct {
        int          cyc;
        logic [3:0]  flags;
        logic [31:0] rs2;
    } issue_t;

    resp_t  resps[$];
    issue_t issues[$];
    resp_t  mon_r;
    issue_t mon_i;

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            mon_r.cyc  = cyc;
            mon_r.port = resp_port;
            mon_r.tag  = resp_tag;
            mon_r.data = resp_data;
            mon_r.addr = resp_addr;
            mon_r.err  = resp_err;
            resps.push_back(mon_r);
        end
        if ((lsu_is_load | lsu_is_store | lsu_is_byte | lsu_is_word) === 1'b1) begin
            mon_i.cyc   = cyc;
            mon_i.flags = {lsu_is_load, lsu_is_store, lsu_is_byte, lsu_is_word};
            mon_i.rs2   = lsu_rs2_data;
            issues.push_back(mon_i);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0; req_is_load = '0; req_is_store = '0; req_is_byte = '0; req_is_word = '0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_tag = '0;
    endtask

    task automatic set_req(input int p, input logic ld, input logic st, input logic by,
                           input logic wd, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [TAG_W-1:0] tag);
        req_valid[p]              = 1'b1;
        req_is_load[p]            = ld;
        req_is_store[p]           = st;
        req_is_byte[p]            = by;
        req_is_word[p]            = wd;
        req_rs1[p*32 +: 32]       = rs1;
        req_rs2[p*32 +: 32]       = rs2;
        req_imm[p*32 +: 32]       = imm;
        req_tag[p*TAG_W +: TAG_W] = tag;
    endtask

    task automatic expect_resp(input string nm, input int idx, input int ecyc, input logic eport,
                               input logic [TAG_W-1:0] etag, input logic [31:0] edata,
                               input logic [31:0] eaddr, input logic eerr);
        if (idx < resps.size()) begin
            check_eq({nm, "_cyc"},  64'(resps[idx].cyc), 64'(ecyc));
            check_eq({nm, "_port"}, 64'(resps[idx].port), 64'(eport));
            check_eq({nm, "_tag"},  64'(resps[idx].tag), 64'(etag));
            check_eq({nm, "_data"}, 64'(resps[idx].data), 64'(edata));
            check_eq({nm, "_addr"}, 64'(resps[idx].addr), 64'(eaddr));
            check_eq({nm, "_err"},  64'(resps[idx].err), 64'(eerr));
        end else begin
            check_eq({nm, "_present"}, 64'(resps.size()), 64'(idx + 1));
        end
    endtask

    task automatic expect_issue(input string nm, input int ecyc, input logic [3:0] eflags,
                                input logic [31:0] ers2);
        check_eq({nm, "_issue_cnt"}, 64'(issues.size()), 64'd1);
        if (issues.size() > 0) begin
            check_eq({nm, "_issue_cyc"}, 64'(issues[0].cyc), 64'(ecyc));
            check_eq({nm, "_issue_flags"}, 64'(issues[0].flags), 64'(eflags));
            check_eq({nm, "_issue_rs2"}, 64'(issues[0].rs2), 64'(ers2));
        end
    endtask

    int n0;
    int acc;

    initial begin
        reset = 1'b0;
        auto_done = 1'b1;
        lsu_read_data = '0;
        clear_req();
        repeat (2) tick();
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_flags", 64'({lsu_is_load, lsu_is_store, lsu_is_byte, lsu_is_word}), 64'd0);
        reset = 1'b1;
        tick();
        check_eq("ready_after_rst", 64'(req_ready), 64'd3);

        // Single word load on port 1
        resps.delete(); issues.delete();
        lsu_read_data = 32'hDEADBEEF;
        n0 = cyc;
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h4, 6'd5);
        tick(); clear_req();
        repeat (6) tick();
        expect_issue("t1", n0 + 2, 4'b1001, 32'h0);
        check_eq("t1_resp_cnt", 64'(resps.size()), 64'd1);
        expect_resp("t1", 0, n0 + 4, 1'b1, 6'd5, 32'hDEADBEEF, 32'h104, 1'b0);
        check_eq("t1_idle", 64'(busy), 64'd0);

        // Contention: two ops per port, alternating grants
        resps.delete(); issues.delete();
        lsu_read_data = 32'h55;
        n0 = cyc;
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h0, 32'h0, 6'd10);
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h0, 32'h0, 6'd20);
        tick();
        check_eq("t2_ready_second", 64'(req_ready), 64'd3);
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1100, 32'h0, 32'h0, 6'd11);
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2100, 32'h0, 32'h0, 6'd21);
        tick(); clear_req();
        repeat (18) tick();
        check_eq("t2_resp_cnt", 64'(resps.size()), 64'd4);
        expect_resp("t2_r0", 0, n0 + 4,  1'b0, 6'd10, 32'h55, 32'h1000, 1'b0);
        expect_resp("t2_r1", 1, n0 + 8,  1'b1, 6'd20, 32'h55, 32'h2000, 1'b0);
        expect_resp("t2_r2", 2, n0 + 12, 1'b0, 6'd11, 32'h55, 32'h1100, 1'b0);
        expect_resp("t2_r3", 3, n0 + 16, 1'b1, 6'd21, 32'h55, 32'h2100, 1'b0);

        // Backpressure on port 0 while port 1 is in flight
        resps.delete(); issues.delete();
        n0 = cyc;
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h0, 6'd30);
        tick(); clear_req();
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400 + 32'(acc * 4), 32'h0, 32'h0,
                    6'(40 + acc));
            check_eq($sformatf("t3_ready%0d", k), 64'(req_ready[0]), (k < 2) ? 64'd1 : 64'd0);
            if (req_ready[0]) acc++;
            tick();
        end
        clear_req();
        repeat (12) tick();
        check_eq("t3_accepts", 64'(acc), 64'd2);
        check_eq("t3_resp_cnt", 64'(resps.size()), 64'd3);
        expect_resp("t3_r0", 0, n0 + 4,  1'b1, 6'd30, 32'h55, 32'h300, 1'b0);
        expect_resp("t3_r1", 1, n0 + 8,  1'b0, 6'd40, 32'h55, 32'h400, 1'b0);
        expect_resp("t3_r2", 2, n0 + 12, 1'b0, 6'd41, 32'h55, 32'h404, 1'b0);

        // Byte store: data must be 0 despite read data on the bus
        resps.delete(); issues.delete();
        lsu_read_data = 32'h1234;
        n0 = cyc;
        set_req(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'hAB, 32'h1, 6'd3);
        tick(); clear_req();
        repeat (6) tick();
        expect_issue("t4", n0 + 2, 4'b0110, 32'hAB);
        expect_resp("t4", 0, n0 + 4, 1'b0, 6'd3, 32'h0, 32'h201, 1'b0);

        // Malformed (load and store): IDLE then RESP, no LSU activity
        resps.delete(); issues.delete();
        n0 = cyc;
        set_req(0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 32'h0, 6'd7);
        tick(); clear_req();
        repeat (5) tick();
        check_eq("t5_issue_cnt", 64'(issues.size()), 64'd0);
        check_eq("t5_resp_cnt", 64'(resps.size()), 64'd1);
        expect_resp("t5", 0, n0 + 2, 1'b0, 6'd7, 32'h0, 32'h0, 1'b1);

        // Watchdog timeout, then a normal op
        resps.delete(); issues.delete();
        auto_done = 1'b0;
        lsu_read_data = 32'hCAFE;
        n0 = cyc;
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h0, 32'h8, 6'd9);
        tick(); clear_req();
        repeat (TIMEOUT + 6) tick();
        expect_issue("t6", n0 + 2, 4'b1001, 32'h0);
        check_eq("t6_resp_cnt", 64'(resps.size()), 64'd1);
        expect_resp("t6", 0, n0 + 2 + TIMEOUT + 2, 1'b1, 6'd9, 32'h0, 32'h608, 1'b1);
        resps.delete(); issues.delete();
        auto_done = 1'b1;
        n0 = cyc;
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0, 32'h0, 6'd12);
        tick(); clear_req();
        repeat (6) tick();
        expect_resp("t6_next", 0, n0 + 4, 1'b0, 6'd12, 32'hCAFE, 32'h700, 1'b0);

        // Reset while in WAIT with the other FIFO still holding a request
        auto_done = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h800, 32'h0, 32'h0, 6'd13);
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h900, 32'h0, 32'h0, 6'd14);
        tick(); clear_req();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_eq("t7_busy", 64'(busy), 64'd0);
        check_eq("t7_ready", 64'(req_ready), 64'd0);
        check_eq("t7_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("t7_flags", 64'({lsu_is_load, lsu_is_store, lsu_is_byte, lsu_is_word}), 64'd0);
        check_eq("t7_rs1", 64'(lsu_rs1_data), 64'd0);
        check_eq("t7_resp_tag", 64'(resp_tag), 64'd0);
        check_eq("t7_resp_addr", 64'(resp_addr), 64'd0);
        resps.delete(); issues.delete();
        #1;
        reset = 1'b1;
        auto_done = 1'b1;
        repeat (8) tick();
        check_eq("t7_no_resp", 64'(resps.size()), 64'd0);
        check_eq("t7_no_issue", 64'(issues.size()), 64'd0);
        check_eq("t7_busy_after", 64'(busy), 64'd0);
        check_eq("t7_ready_after", 64'(req_ready), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
